pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//   Parametrised elastic register chain: DEPTH stages of WIDTH-bit data, each with a valid bit,
//   valid/ready handshakes at both ends, bubble collapsing and synchronous flush. Successor to the
//   plain async-reset datapath register; used between multicycle datapath units (IR/MDR/ALUOut
//   paths) where a consumer may stall and a control event must discard in-flight data.
// PARAMETERS
//   WIDTH      32  data width in bits (>=1)
//   DEPTH      3   number of register stages (>=1)
//   RESET_VAL  0   value loaded into every data register on reset (WIDTH bits)
// PORTS
//   clk        in   1                 rising-edge clock
//   reset      in   1                 asynchronous, active-low reset
//   in_valid   in   1                 producer presents in_data
//   in_data    in   WIDTH             input word
//   in_ready   out  1                 chain accepts in_data this cycle
//   out_valid  out  1                 stage DEPTH-1 holds a valid word
//   out_data   out  WIDTH             data of stage DEPTH-1
//   out_ready  in   1                 consumer takes out_data this cycle
//   flush      in   1                 synchronous discard of all in-flight words
//   occupancy  out  $clog2(DEPTH+1)   number of valid stages (0..DEPTH)
// BEHAVIOUR
//   - Reset (reset=0, async): all valid[i]=0, all data[i]=RESET_VAL, occupancy=0, out_valid=0;
//     in_ready=1 once reset released (flush=0). Reset mid-transfer drops everything, no output.
//   - Transfer: input accepted when in_valid&in_ready; output consumed when out_valid&out_ready.
//   - Stage move (combinational): mv[DEPTH-1]=valid[DEPTH-1]&out_ready;
//     mv[i]=valid[i]&(~valid[i+1]|mv[i+1]) for i<DEPTH-1. in_ready=(~valid[0]|mv[0])&~flush.
//   - Stage i>0 loads data[i-1] when mv[i-1]; stage 0 loads in_data on input accept.
//     valid[i] next = load_i | (valid[i]&~mv[i]). Data regs hold when not loaded (no enable glitch).
//   - Bubble collapse: an empty stage is refilled from upstream even while out_ready=0, so
//     DEPTH words are stored when the consumer stalls; full chain + out_ready=1 + in_valid=1
//     sustains 1 word/cycle (ready path is combinational through the chain).
//   - Latency: word accepted at edge N appears on out_valid after edge N+DEPTH-1 (DEPTH edges
//     in->out register path; out_data valid DEPTH-1 cycles after the accept edge's cycle).
//   - Order preserved; no word duplicated or lost except by flush/reset.
//   - Flush (sampled at edge): all valid next=0, occupancy next=0; in_ready=0 during flush
//     cycle (input not taken); an output handshake in the flush cycle counts as delivered.
//     Data regs are not cleared by flush.
//   - occupancy = popcount(valid); registered alongside valid (updated each edge by +accept
//     -consume, forced 0 on flush); never exceeds DEPTH, never underflows.
//   - out_data is the stage register directly (no comb path from in_data to out_data).
//   - DEPTH=1: single skid-free stage; in_ready=~valid|out_ready.
// TESTING
//   1 Reset: WIDTH=32,RESET_VAL=32'hDEADBEEF, pulse reset low mid-stream -> out_valid=0,
//     out_data=32'hDEADBEEF, occupancy=0 immediately (async), in_ready=1 after release.
//   2 Streaming: DEPTH=3, out_ready=1, feed 1,2,3,4 back-to-back -> first out_valid 2 edges after
//     accepting 1, outputs 1,2,3,4 on consecutive cycles, occupancy steady at 3 when saturated.
//   3 Backpressure/collapse: out_ready=0, feed 0xA,0xB,0xC with gaps -> occupancy 1,2,3,
//     in_ready=0 when 3; raise out_ready -> 0xA,0xB,0xC in order, in_ready=1 same cycle as first pop.
//   4 Flush: chain full, assert flush 1 cycle with in_valid=1, out_ready=1 -> head word delivered,
//     input not accepted, next cycle out_valid=0, occupancy=0.
//   5 Randomised valid/ready vs. scoreboard model, DEPTH in {1,2,5}, 10k cycles -> no loss,
//     reorder or duplication; occupancy equals scoreboard count every cycle.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - elastic valid/ready register chain with bubble collapse and flush
module pipe_reg_chain #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [OCC_W-1:0] r_occ;

    logic [DEPTH-1:0] w_mv;
    logic [DEPTH-1:0] w_load;
    logic [WIDTH-1:0] w_din [DEPTH];
    logic             w_accept;
    logic             w_consume;

    // A valid stage advances when the consumer is ready or any later stage
    // is empty; this is the unrolled form of the per-stage ready chain.
    always_comb begin
        logic v_hole;
        v_hole = 1'b0;
        w_mv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_mv[i] = r_valid[i] & (out_ready | v_hole);
            v_hole  = v_hole | ~r_valid[i];
        end
    end

    assign in_ready  = (~r_valid[0] | w_mv[0]) & ~flush;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_valid[DEPTH-1];
    assign out_data  = r_data[DEPTH-1];
    assign w_consume = out_valid & out_ready;
    assign occupancy = r_occ;

    always_comb begin
        w_load    = '0;
        w_load[0] = w_accept;
        w_din[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_load[i] = w_mv[i-1];
            w_din[i]  = r_data[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_load[i]) begin
                    r_data[i] <= w_din[i];
                end
            end
        end
    end

    // Flush drops validity only; data registers keep whatever they loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_load | (r_valid & ~w_mv);
            r_occ   <= r_occ + OCC_W'(w_accept) - OCC_W'(w_consume);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - directed and randomised checks of pipe_reg_chain
module tb_pipe_reg_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_flush;
    logic [31:0] d_in_data, d_out_data;
    logic [1:0]  d_occ;

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'hDEADBEEF)) u_d3 (
        .clk(clk), .reset(reset),
        .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready),
        .out_valid(d_out_valid), .out_data(d_out_data), .out_ready(d_out_ready),
        .flush(d_flush), .occupancy(d_occ)
    );

    logic        rv_in_valid  [3];
    logic [15:0] rv_in_data   [3];
    logic        rv_in_ready  [3];
    logic        rv_out_valid [3];
    logic [15:0] rv_out_data  [3];
    logic        rv_out_ready [3];
    logic        rv_flush     [3];
    logic        occ_r1;
    logic [1:0]  occ_r2;
    logic [2:0]  occ_r5;
    logic [2:0]  rv_occ [3];

    assign rv_occ[0] = {2'b00, occ_r1};
    assign rv_occ[1] = {1'b0, occ_r2};
    assign rv_occ[2] = occ_r5;

    pipe_reg_chain #(.WIDTH(16), .DEPTH(1)) u_r1 (
        .clk(clk), .reset(reset),
        .in_valid(rv_in_valid[0]), .in_data(rv_in_data[0]), .in_ready(rv_in_ready[0]),
        .out_valid(rv_out_valid[0]), .out_data(rv_out_data[0]), .out_ready(rv_out_ready[0]),
        .flush(rv_flush[0]), .occupancy(occ_r1)
    );
    pipe_reg_chain #(.WIDTH(16), .DEPTH(2)) u_r2 (
        .clk(clk), .reset(reset),
        .in_valid(rv_in_valid[1]), .in_data(rv_in_data[1]), .in_ready(rv_in_ready[1]),
        .out_valid(rv_out_valid[1]), .out_data(rv_out_data[1]), .out_ready(rv_out_ready[1]),
        .flush(rv_flush[1]), .occupancy(occ_r2)
    );
    pipe_reg_chain #(.WIDTH(16), .DEPTH(5)) u_r5 (
        .clk(clk), .reset(reset),
        .in_valid(rv_in_valid[2]), .in_data(rv_in_data[2]), .in_ready(rv_in_ready[2]),
        .out_valid(rv_out_valid[2]), .out_data(rv_out_data[2]), .out_ready(rv_out_ready[2]),
        .flush(rv_flush[2]), .occupancy(occ_r5)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] dat, input logic ordy, input logic fl);
        @(negedge clk);
        d_in_valid  = iv;
        d_in_data   = dat;
        d_out_ready = ordy;
        d_flush     = fl;
        #1;
    endtask

    // Scoreboard: each in-flight word keeps its data and its stage index.
    int          dep [3] = '{1, 2, 5};
    logic [15:0] md  [3][64];
    int          mp  [3][64];
    int          rd  [3];
    int          wr  [3];

    initial begin
        int          occ_s [8];
        logic [31:0] bp_d  [3];
        int          cnt, lim, p;
        logic        e_ov, e_ir, cons, acc;

        occ_s = '{0, 1, 2, 3, 3, 2, 1, 0};
        bp_d  = '{32'hA, 32'hB, 32'hC};

        reset = 1'b0;
        d_in_valid = 0; d_in_data = 0; d_out_ready = 0; d_flush = 0;
        for (int k = 0; k < 3; k++) begin
            rv_in_valid[k] = 0; rv_in_data[k] = 0; rv_out_ready[k] = 0; rv_flush[k] = 0;
            rd[k] = 0; wr[k] = 0;
        end

        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", d_out_valid, 0);
        check("reset_out_data", d_out_data, 32'hDEADBEEF);
        check("reset_occ", d_occ, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_in_ready", d_in_ready, 1);

        for (int c = 0; c < 8; c++) begin
            step(c < 4, c + 1, 1, 0);
            check($sformatf("stream_occ[%0d]", c), d_occ, occ_s[c]);
            check($sformatf("stream_ov[%0d]", c), d_out_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check($sformatf("stream_data[%0d]", c), d_out_data, c - 2);
            if (c < 4) check($sformatf("stream_ir[%0d]", c), d_in_ready, 1);
        end

        for (int c = 0; c < 6; c++) begin
            step(c % 2 == 0, bp_d[c/2], 0, 0);
            check($sformatf("bp_occ[%0d]", c), d_occ, (c + 1) / 2);
        end
        check("bp_full_ir", d_in_ready, 0);
        check("bp_full_ov", d_out_valid, 1);
        check("bp_full_data", d_out_data, 32'hA);
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 1, 0);
            if (c == 0) check("bp_pop_ir", d_in_ready, 1);
            check($sformatf("bp_drain_occ[%0d]", c), d_occ, 3 - c);
            check($sformatf("bp_drain_ov[%0d]", c), d_out_valid, c < 3);
            if (c < 3) check($sformatf("bp_drain_data[%0d]", c), d_out_data, bp_d[c]);
        end

        for (int c = 0; c < 3; c++) step(1, 32'h11 * (c + 1), 0, 0);
        step(1, 32'h44, 1, 1);
        check("flush_ir", d_in_ready, 0);
        check("flush_ov", d_out_valid, 1);
        check("flush_head", d_out_data, 32'h11);
        check("flush_occ_before", d_occ, 3);
        step(0, 0, 1, 0);
        check("flush_ov_after", d_out_valid, 0);
        check("flush_occ_after", d_occ, 0);
        check("flush_ir_after", d_in_ready, 1);
        step(0, 0, 1, 0);
        check("flush_no_input", d_out_valid, 0);

        step(1, 32'h55, 0, 0);
        step(1, 32'h66, 0, 0);
        step(0, 0, 0, 0);
        check("midreset_occ_before", d_occ, 2);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_ov", d_out_valid, 0);
        check("midreset_data", d_out_data, 32'hDEADBEEF);
        check("midreset_occ", d_occ, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_ir", d_in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 1, 0);
            check($sformatf("midreset_drop[%0d]", c), d_out_valid, 0);
        end

        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                rv_in_valid[k]  = ($urandom_range(99) < 70);
                rv_in_data[k]   = 16'($urandom);
                rv_out_ready[k] = ((cyc / 1000) % 2 == 0) ? ($urandom_range(99) < 30)
                                                          : ($urandom_range(99) < 80);
                rv_flush[k]     = ($urandom_range(99) < 1);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                cnt  = wr[k] - rd[k];
                e_ov = (cnt > 0) && (mp[k][rd[k] & 63] == dep[k] - 1);
                e_ir = !rv_flush[k] && (cnt < dep[k] || rv_out_ready[k]);
                check($sformatf("rnd_d%0d_ov[%0d]", dep[k], cyc), rv_out_valid[k], e_ov);
                check($sformatf("rnd_d%0d_ir[%0d]", dep[k], cyc), rv_in_ready[k], e_ir);
                check($sformatf("rnd_d%0d_occ[%0d]", dep[k], cyc), rv_occ[k], cnt);
                if (e_ov) check($sformatf("rnd_d%0d_data[%0d]", dep[k], cyc),
                                rv_out_data[k], md[k][rd[k] & 63]);
                cons = e_ov && rv_out_ready[k];
                acc  = rv_in_valid[k] && e_ir;
                if (rv_flush[k]) begin
                    rd[k] = wr[k];
                end else begin
                    if (cons) rd[k]++;
                    lim = dep[k] - 1;
                    for (int j = rd[k]; j < wr[k]; j++) begin
                        p = mp[k][j & 63] + 1;
                        if (p > lim) p = lim;
                        mp[k][j & 63] = p;
                        lim = p - 1;
                    end
                    if (acc) begin
                        md[k][wr[k] & 63] = rv_in_data[k];
                        mp[k][wr[k] & 63] = 0;
                        wr[k]++;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
